// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with majority-vote sampling and valid/ready hand-off
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int DIV_CALC = (CLK_FREQ_HZ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W    = 4;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

    state_t               state, state_nxt;
    logic                 sync1, sync2;
    logic [1:0]           settle;
    logic                 armed;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      os_cnt, os_idx;
    logic                 tick, mid, s_a, s_b, vote;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc, perr_acc, done;
    logic                 start_det, last_data, last_stop;

    // The preset sync value is not trusted as "line seen idle": arming waits until
    // the synchroniser has flushed real pin samples after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            sync1 <= rxd_i;
            sync2 <= sync1;
            if (settle != 2'd2) settle <= settle + 2'd1;
            if (settle == 2'd2 && sync2) armed <= 1'b1;
        end
    end

    assign start_det = (state == S_IDLE) && armed && !sync2;
    assign tick      = (div_cnt == DIV_W'(DIV - 1));
    assign os_idx    = (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
    assign mid       = tick && (os_idx == OS_W'(OVERSAMPLE / 2 + 1));
    assign vote      = (s_a & s_b) | (s_a & sync2) | (s_b & sync2);
    assign last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || start_det) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= os_idx;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_a <= 1'b1;
            s_b <= 1'b1;
        end else if (tick) begin
            if (os_idx == OS_W'(OVERSAMPLE / 2 - 1)) s_a <= sync2;
            if (os_idx == OS_W'(OVERSAMPLE / 2))     s_b <= sync2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_det) state_nxt = S_START;
            S_START: if (mid) state_nxt = vote ? S_IDLE : S_DATA;
            S_DATA:  if (mid && last_data) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (mid) state_nxt = S_STOP;
            // An all-zero word with a bad stop is a break: hold off until the line idles.
            S_STOP:  if (mid && last_stop)
                         state_nxt = ((shreg == '0) && (ferr_acc || !vote)) ? S_BRK : S_IDLE;
            S_BRK:   if (sync2) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start_det) begin
                    bit_cnt  <= '0;
                    ferr_acc <= 1'b0;
                    perr_acc <= 1'b0;
                end
                S_DATA: if (mid) begin
                    shreg   <= {vote, shreg[DATA_BITS-1:1]};
                    bit_cnt <= last_data ? '0 : bit_cnt + BIT_W'(1);
                end
                S_PAR: if (mid) begin
                    perr_acc <= (PARITY == 1) ? ~(^shreg ^ vote) : (^shreg ^ vote);
                end
                S_STOP: if (mid) begin
                    ferr_acc <= ferr_acc | ~vote;
                    bit_cnt  <= bit_cnt + BIT_W'(1);
                    done     <= last_stop;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (done) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o    <= shreg;
                    frame_err_o  <= ferr_acc;
                    parity_err_o <= perr_acc;
                    rx_valid_o   <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed bench for uart_rx_cfg (8N1 defaults and a fast 7E2 instance)
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int BCLK  = 432;
    localparam int BCLKF = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rdy = 1'b1;
    logic [7:0] data;
    logic       valid, fe, pe, ovr, busy;
    logic       rxd_f = 1'b1;
    logic       rdy_f = 1'b1;
    logic [6:0] data_f;
    logic       valid_f, fe_f, pe_f, ovr_f, busy_f;

    always #10 clk = ~clk;

    uart_rx_cfg u_dut (
        .clk_i(clk), .rst_i(rst), .rxd_i(rxd), .rx_data_o(data), .rx_valid_o(valid),
        .rx_ready_i(rdy), .frame_err_o(fe), .parity_err_o(pe), .overrun_o(ovr), .busy_o(busy)
    );

    uart_rx_cfg #(
        .CLK_FREQ_HZ(3_686_400), .BAUD_RATE(115200), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(8)
    ) u_fast (
        .clk_i(clk), .rst_i(rst), .rxd_i(rxd_f), .rx_data_o(data_f), .rx_valid_o(valid_f),
        .rx_ready_i(rdy_f), .frame_err_o(fe_f), .parity_err_o(pe_f), .overrun_o(ovr_f), .busy_o(busy_f)
    );

    logic [7:0] acc_d [0:63];
    logic       acc_fe[0:63];
    logic       acc_pe[0:63];
    int         acc_n = 0;
    logic [7:0] accf_d [0:15];
    logic       accf_fe[0:15];
    logic       accf_pe[0:15];
    int         accf_n = 0;
    int         vcyc = 0;
    int         ovr_n = 0;
    int         ovrf_n = 0;

    // Passive log of handshakes and pulses; all judgement happens in the main sequence.
    always @(negedge clk) begin
        if (valid && rdy && acc_n < 64) begin
            acc_d[acc_n]  = data;
            acc_fe[acc_n] = fe;
            acc_pe[acc_n] = pe;
            acc_n++;
        end
        if (valid_f && rdy_f && accf_n < 16) begin
            accf_d[accf_n]  = {1'b0, data_f};
            accf_fe[accf_n] = fe_f;
            accf_pe[accf_n] = pe_f;
            accf_n++;
        end
        if (valid) vcyc++;
        if (ovr)   ovr_n++;
        if (ovr_f) ovrf_n++;
    end

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int which, input logic [15:0] bits, input int n,
                        input int bclk, input int rst_bit);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rxd = bits[i];
            else            rxd_f = bits[i];
            for (int c = 0; c < bclk; c++) begin
                @(negedge clk);
                if (i == rst_bit && c == bclk / 2)     rst = 1'b1;
                if (i == rst_bit && c == bclk / 2 + 2) rst = 1'b0;
            end
        end
    endtask

    function automatic logic [15:0] f8(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] f7e2(input logic [6:0] d, input logic p);
        return {5'b0, 2'b11, p, d, 1'b0};
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_fe;
    } vec_t;

    vec_t tbl[5];
    int   b_acc, b_v, b_ovr, wait_n;

    initial begin
        tbl[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
        tbl[1] = '{8'hAA, 1'b1, 8'hAA, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        tbl[4] = '{8'hA5, 1'b0, 8'hA5, 1'b1};

        idle(4);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_fe", fe, 0);
        chk("rst_pe", pe, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        idle(8);

        for (int k = 0; k < 5; k++) begin
            b_acc = acc_n;
            b_v   = vcyc;
            send(0, f8(tbl[k].d, tbl[k].stop), 10, BCLK, -1);
            rxd = 1'b1;
            idle(2 * BCLK);
            chk($sformatf("vec%0d_count", k), acc_n - b_acc, 1);
            chk($sformatf("vec%0d_data", k), acc_d[b_acc], tbl[k].exp_d);
            chk($sformatf("vec%0d_fe", k), acc_fe[b_acc], tbl[k].exp_fe);
            chk($sformatf("vec%0d_pe", k), acc_pe[b_acc], 0);
            chk($sformatf("vec%0d_vcyc", k), vcyc - b_v, 1);
        end

        rdy   = 1'b0;
        b_acc = acc_n;
        b_ovr = ovr_n;
        send(0, f8(8'h55, 1'b1), 10, BCLK, -1);
        send(0, f8(8'hAA, 1'b1), 10, BCLK, -1);
        send(0, f8(8'hF0, 1'b1), 10, BCLK, -1);
        rxd = 1'b1;
        idle(10);
        chk("ovr_held_valid", valid, 1);
        chk("ovr_held_data", data, 8'h55);
        chk("ovr_pulses", ovr_n - b_ovr, 2);
        chk("ovr_no_accept", acc_n - b_acc, 0);
        rdy = 1'b1;
        idle(4);
        chk("ovr_accept_count", acc_n - b_acc, 1);
        chk("ovr_accept_data", acc_d[b_acc], 8'h55);
        chk("ovr_valid_clear", valid, 0);

        b_v = vcyc;
        rxd = 1'b0;
        idle(100);
        rxd = 1'b1;
        wait_n = 0;
        while (busy && wait_n < BCLK) begin
            idle(1);
            wait_n++;
        end
        chk("glitch_busy_clear", busy, 0);
        idle(BCLK);
        chk("glitch_no_valid", vcyc - b_v, 0);

        b_acc = acc_n;
        send(0, 16'h0000, 10, BCLK, -1);
        idle(5 * BCLK);
        chk("brk_count", acc_n - b_acc, 1);
        chk("brk_data", acc_d[b_acc], 8'h00);
        chk("brk_fe", acc_fe[b_acc], 1);
        chk("brk_busy_low", busy, 1);
        rxd = 1'b1;
        idle(2 * BCLK);
        chk("brk_no_more", acc_n - b_acc, 1);
        chk("brk_busy_idle", busy, 0);

        b_acc = acc_n;
        b_v   = vcyc;
        send(0, f8(8'hC3, 1'b1), 10, BCLK, 4);
        rxd = 1'b1;
        idle(2 * BCLK);
        chk("rstmid_no_accept", acc_n - b_acc, 0);
        chk("rstmid_no_valid", vcyc - b_v, 0);
        send(0, f8(8'h3C, 1'b1), 10, BCLK, -1);
        rxd = 1'b1;
        idle(2 * BCLK);
        chk("rstmid_next_count", acc_n - b_acc, 1);
        chk("rstmid_next_data", acc_d[b_acc], 8'h3C);
        chk("rstmid_next_fe", acc_fe[b_acc], 0);

        b_acc = accf_n;
        send(1, f7e2(7'h35, 1'b1), 11, BCLKF, -1);
        rxd_f = 1'b1;
        idle(2 * BCLKF);
        send(1, f7e2(7'h35, 1'b0), 11, BCLKF, -1);
        rxd_f = 1'b1;
        idle(2 * BCLKF);
        chk("par_count", accf_n - b_acc, 2);
        chk("par_bad_data", accf_d[b_acc], 8'h35);
        chk("par_bad_pe", accf_pe[b_acc], 1);
        chk("par_bad_fe", accf_fe[b_acc], 0);
        chk("par_good_data", accf_d[b_acc + 1], 8'h35);
        chk("par_good_pe", accf_pe[b_acc + 1], 0);
        chk("par_no_ovr", ovrf_n, 0);
        chk("par_busy_idle", busy_f, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
